// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider serving DIV (signed) and DIVU (unsigned).
// One subtract-and-test step per cycle for WIDTH cycles, then a sign-fixup cycle.
// Quotient truncates toward zero; the remainder takes the sign of the dividend.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset; aborts any operation in progress
//   start    request, sampled only while busy=0 (also accepted in the done cycle)
//   sign     1 = signed divide, 0 = unsigned; captured with start
//   busA     dividend, captured with start
//   busB     divisor, captured with start
//   busLO    quotient register (all ones on divide by zero)
//   busHI    remainder register (original dividend on divide by zero)
//   busy     operation in progress
//   done     one-cycle pulse, results valid
//   divZero  divisor was zero; valid with done, held until the next done
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] busA,
  input  logic [WIDTH-1:0] busB,
  output logic [WIDTH-1:0] busLO,
  output logic [WIDTH-1:0] busHI,
  output logic             busy,
  output logic             done,
  output logic             divZero
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StDiv, StFix} stateT;

  stateT            stateQ, stateD;
  logic [CntW-1:0]  cntQ, cntD;
  logic [WIDTH-1:0] remQ, remD;     // partial remainder
  logic [WIDTH-1:0] dvdQ, dvdD;     // dividend magnitude, shifted out as quotient bits shift in
  logic [WIDTH-1:0] divQ, divD;     // divisor magnitude
  logic             qNegQ, qNegD;
  logic             rNegQ, rNegD;
  logic             zeroQ, zeroD;
  logic [WIDTH-1:0] loQ, loD;
  logic [WIDTH-1:0] hiQ, hiD;
  logic             dzQ, dzD;
  logic             doneQ, doneD;

  logic [WIDTH:0]   shifted;
  logic             borrow;
  logic [WIDTH-1:0] trial;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next-state logic
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle:  if (start) stateD = StDiv;
      StDiv:   if (cntQ == '0) stateD = StFix;
      StFix:   stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (stateQ != StIdle);
  end

  // The shifted remainder needs WIDTH+1 bits: it can exceed 2^WIDTH-1 when the divisor has its
  // MSB set. When no borrow occurs the difference is below the divisor, so a WIDTH-bit modular
  // subtract yields the exact new remainder.
  always_comb begin
    shifted = {remQ, dvdQ[WIDTH-1]};
    borrow  = shifted < {1'b0, divQ};
    trial   = shifted[WIDTH-1:0] - divQ;
  end

  // Datapath next-state
  always_comb begin
    cntD  = cntQ;
    remD  = remQ;
    dvdD  = dvdQ;
    divD  = divQ;
    qNegD = qNegQ;
    rNegD = rNegQ;
    zeroD = zeroQ;
    loD   = loQ;
    hiD   = hiQ;
    dzD   = dzQ;
    doneD = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (start) begin
          dvdD  = (sign && busA[WIDTH-1]) ? -busA : busA;
          divD  = (sign && busB[WIDTH-1]) ? -busB : busB;
          qNegD = sign & (busA[WIDTH-1] ^ busB[WIDTH-1]);
          rNegD = sign & busA[WIDTH-1];
          zeroD = (busB == '0);
          remD  = '0;
          cntD  = CntW'(WIDTH - 1);
        end
      end
      StDiv: begin
        dvdD = {dvdQ[WIDTH-2:0], ~borrow};
        remD = borrow ? shifted[WIDTH-1:0] : trial;
        if (cntQ != '0) cntD = cntQ - CntW'(1);
      end
      StFix: begin
        // With a zero divisor the loop leaves |A| in the remainder, so the normal sign fixup
        // already restores the original dividend; only the quotient needs forcing.
        loD   = zeroQ ? '1 : (qNegQ ? -dvdQ : dvdQ);
        hiD   = rNegQ ? -remQ : remQ;
        dzD   = zeroQ;
        doneD = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cntQ  <= '0;
      remQ  <= '0;
      dvdQ  <= '0;
      divQ  <= '0;
      qNegQ <= 1'b0;
      rNegQ <= 1'b0;
      zeroQ <= 1'b0;
      loQ   <= '0;
      hiQ   <= '0;
      dzQ   <= 1'b0;
      doneQ <= 1'b0;
    end else begin
      cntQ  <= cntD;
      remQ  <= remD;
      dvdQ  <= dvdD;
      divQ  <= divD;
      qNegQ <= qNegD;
      rNegQ <= rNegD;
      zeroQ <= zeroD;
      loQ   <= loD;
      hiQ   <= hiD;
      dzQ   <= dzD;
      doneQ <= doneD;
    end
  end

  assign busLO   = loQ;
  assign busHI   = hiQ;
  assign divZero = dzQ;
  assign done    = doneQ;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: the driver pushes reference results, the monitor pops and
// compares whenever done pulses, and checks hold/exclusivity/latency on every other cycle.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sign = 1'b0;
  logic [31:0] busA = '0;
  logic [31:0] busB = '0;
  logic [31:0] busLO, busHI;
  logic        busy, done, divZero;

  seq_divider #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sign   (sign),
    .busA   (busA),
    .busB   (busB),
    .busLO  (busLO),
    .busHI  (busHI),
    .busy   (busy),
    .done   (done),
    .divZero(divZero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
    int unsigned cyc;
  } expT;

  expT         sbq[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, req, $time);
    end
  endtask

  // Reference: plain integer division at 64 bits, so signed overflow wraps naturally.
  function automatic expT model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                input int unsigned c);
    expT    e;
    longint sa, sb, q, r;
    e.cyc = c;
    e.dz  = 1'b0;
    if (b == 32'd0) begin
      e.lo = 32'hFFFFFFFF;
      e.hi = a;
      e.dz = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      e.lo = q[31:0];
      e.hi = r[31:0];
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction

  // Monitor
  logic [31:0] heldLo = '0;
  logic [31:0] heldHi = '0;
  logic        heldDz = 1'b0;
  int          busyCnt = 0;

  always @(negedge clk) begin
    expT e;
    if (!rst_n) begin
      heldLo  = '0;
      heldHi  = '0;
      heldDz  = 1'b0;
      busyCnt = 0;
      sbq.delete();
    end else begin
      if (busy && done) check("busy_done_both_high", 32'(busy & done), 32'd0);
      if (done) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending operation at t=%0t",
                   $time);
        end else begin
          e = sbq.pop_front();
          check("quotient", busLO, e.lo);
          check("remainder", busHI, e.hi);
          check("divZero", 32'(divZero), 32'(e.dz));
          check("latency_cycle", cyc, e.cyc);
          check("busy_cycles", busyCnt, 33);
          heldLo = e.lo;
          heldHi = e.hi;
          heldDz = e.dz;
        end
        busyCnt = 0;
      end else begin
        check("hold_lo", busLO, heldLo);
        check("hold_hi", busHI, heldHi);
        check("hold_dz", 32'(divZero), 32'(heldDz));
        if (busy) busyCnt++;
      end
    end
  end

  // Called at a negedge while busy=0; the start edge is the following posedge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    sbq.push_back(model(a, b, s, cyc + 34));
    busA  = a;
    busB  = b;
    sign  = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    busA  = $urandom;
    busB  = $urandom;
    sign  = 1'($urandom_range(0, 1));
  endtask

  task automatic waitDone();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles");
    end
  endtask

  logic [31:0] dirA[11] = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF,
                            32'd1234, 32'd100, 32'h80000000, 32'hFFFFFFF9, 32'd0,
                            32'h80000000};
  logic [31:0] dirB[11] = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'd2, 32'd2,
                            32'd0, 32'd7, 32'hFFFFFFFF, 32'd0, 32'd5,
                            32'h80000000};
  logic        dirS[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    logic [31:0] a, b;
    int          sel;
    #1;
    check("reset_lo", busLO, 32'd0);
    check("reset_hi", busHI, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_dz", 32'(divZero), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases, issued back-to-back in each done cycle
    for (int i = 0; i < 11; i++) begin
      issue(dirA[i], dirB[i], dirS[i]);
      waitDone();
    end

    // Idle gap, then start pulses during busy must be ignored
    repeat (3) @(negedge clk);
    issue(32'd1000, 32'd3, 1'b0);
    repeat (5) @(negedge clk);
    busA  = $urandom;
    busB  = $urandom | 32'd1;
    sign  = 1'b1;
    start = 1'b1;
    repeat (10) @(negedge clk);
    start = 1'b0;
    waitDone();

    // Randomized operations
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 9);
      a   = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case (sel)
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = 32'hFFFFFFFF;
        3:       b = $urandom_range(1, 15);
        4:       b = 32'h80000000 | $urandom;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      issue(a, b, 1'($urandom_range(0, 1)));
      waitDone();
    end

    // Asynchronous reset in the middle of an operation
    issue(32'd5000, 32'd3, 1'b0);
    waitDone();
    issue(32'd100, 32'd7, 1'b1);
    repeat (9) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_lo", busLO, 32'd0);
    check("abort_hi", busHI, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_dz", 32'(divZero), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    // Recovery after reset
    issue(32'hFFFFFFF9, 32'd2, 1'b1);
    waitDone();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got simulation still running expected finish");
    $fatal(1, "timeout");
  end

endmodule
